// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file arbiter.
package rf_arb_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;

    // Sequencer states: wait for a grant, strobe the file, take the read data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/rf_arbiter_if.sv
// Bundles both requester ports and the Register_File strobe bus.
// The slave modport is the arbiter's view; master is the requester/file side.
interface rf_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
);
    logic          req0_valid;
    logic          req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wr_data;
    logic          req0_ready;

    logic          req1_valid;
    logic          req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wr_data;
    logic          req1_ready;

    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [DW-1:0] rsp_rd_data;
    logic          busy;

    logic          rf_wr_en;
    logic          rf_rd_en;
    logic [AW-1:0] rf_address;
    logic [DW-1:0] rf_wr_data;
    logic [DW-1:0] rf_rd_data;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wr_data,
        input  req1_valid, req1_wr, req1_addr, req1_wr_data,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rd_data, busy,
        output rf_wr_en, rf_rd_en, rf_address, rf_wr_data,
        input  rf_rd_data
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wr_data,
        output req1_valid, req1_wr, req1_addr, req1_wr_data,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rd_data, busy,
        input  rf_wr_en, rf_rd_en, rf_address, rf_wr_data,
        output rf_rd_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a one-bit priority pointer.
// The pointer only moves on an accepted grant, toward the loser.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Grant: the pointer holder wins a tie, a lone requester always wins.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            o_gnt[0] = i_req[0] & (~r_ptr | ~i_req[1]);
            o_gnt[1] = i_req[1] & ( r_ptr | ~i_req[0]);
        end
    end

    // Pointer: hand priority to the requester that was not served.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_gnt[1];
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share one
// single-port Register_File: accept, strobe for one cycle, return read data.
module rf_arbiter
    import rf_arb_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    rf_arbiter_if.slave  bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_accept;
    logic                  w_en;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  r_wr;
    logic                  r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_valid;

    assign w_req    = {bus.req1_valid, bus.req0_valid};
    assign w_accept = |w_gnt;
    // State is already IDLE during reset; the extra term keeps Ready low while reset is held.
    assign w_en     = (r_state == IDLE) & i_rst_n;

    rr_arb2 u_rr_arb2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (w_req),
        .i_en     (w_en),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the one-cycle file strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_wr_en     = r_wr;
                w_rd_en     = ~r_wr;
                w_state_nxt = r_wr ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch: the winner's fields are sampled only at the accept edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr      <= 1'b0;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr      <= w_gnt[1] ? bus.req1_wr      : bus.req0_wr;
            r_owner   <= w_gnt[1];
            r_addr    <= w_gnt[1] ? bus.req1_addr    : bus.req0_addr;
            r_wr_data <= w_gnt[1] ? bus.req1_wr_data : bus.req0_wr_data;
        end
    end

    // Response: register file data in CAPTURE and pulse the owner's valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (r_state == CAPTURE) begin
                r_rsp_data  <= bus.rf_rd_data;
                r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            end
        end
    end

    assign bus.req0_ready  = w_gnt[0];
    assign bus.req1_ready  = w_gnt[1];
    assign bus.rsp0_valid  = r_rsp_valid[0];
    assign bus.rsp1_valid  = r_rsp_valid[1];
    assign bus.rsp_rd_data = r_rsp_data;
    assign bus.busy        = (r_state != IDLE);
    assign bus.rf_wr_en    = w_wr_en;
    assign bus.rf_rd_en    = w_rd_en;
    assign bus.rf_address  = r_addr;
    assign bus.rf_wr_data  = r_wr_data;

endmodule

// File: tb/tb_rf_arbiter.sv
// Self-checking bench for rf_arbiter: directed scenarios plus random traffic,
// each cycle compared against a transaction-level model of the arbiter.
module tb_rf_arbiter;
    import rf_arb_pkg::*;

    typedef struct {
        bit        wr;
        bit [2:0]  addr;
        bit [15:0] data;
        int        delay;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_arbiter_if bus ();

    rf_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Register_File behaviour: write at the strobe edge, read data registered at the strobe edge.
    logic [15:0] rf_mem [8] = '{default: 16'h0};
    logic [15:0] rf_rd_q    = 16'h0;
    always @(posedge clk) begin
        if (bus.rf_wr_en) rf_mem[bus.rf_address] <= bus.rf_wr_data;
        if (bus.rf_rd_en) rf_rd_q <= rf_mem[bus.rf_address];
    end
    assign bus.rf_rd_data = rf_rd_q;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (cycle index counts edges since reset release).
    txn_t      q0[$];
    txn_t      q1[$];
    bit [15:0] ref_mem [8] = '{default: 16'h0};
    int        now, free_at, ptr, strobe_cyc, rsp_cyc, rsp_owner;
    bit        strobe_wr;
    bit [2:0]  last_addr;
    bit [15:0] last_wdata, last_rsp, rsp_exp;

    // Observation logs for scenario-level checks.
    int        wren_cnt, rsp0_cnt, rsp1_cnt;
    bit [2:0]  wren_addr;
    bit [15:0] wren_data;
    bit [15:0] rsp0_data[$];
    bit [15:0] rsp1_data[$];
    int        gnt_log[$];
    int        acc1_cyc[$];
    int        rdy0_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit wr, input bit [2:0] addr, input bit [15:0] data, input int delay);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.delay = delay;
        return t;
    endfunction

    task automatic model_reset();
        now = 0; free_at = 0; ptr = 0; strobe_cyc = -1; rsp_cyc = -1; rsp_owner = 0;
        strobe_wr = 1'b0; last_addr = '0; last_wdata = '0; last_rsp = '0; rsp_exp = '0;
    endtask

    task automatic clear_mon();
        wren_cnt = 0; rsp0_cnt = 0; rsp1_cnt = 0; wren_addr = '0; wren_data = '0;
        rsp0_data.delete(); rsp1_data.delete(); gnt_log.delete(); acc1_cyc.delete(); rdy0_cyc.delete();
    endtask

    task automatic drive();
        if (q0.size() > 0 && q0[0].delay == 0) begin
            bus.req0_valid = 1'b1; bus.req0_wr = q0[0].wr;
            bus.req0_addr = q0[0].addr; bus.req0_wr_data = q0[0].data;
        end else begin
            bus.req0_valid = 1'b0; bus.req0_wr = 1'($urandom);
            bus.req0_addr = 3'($urandom); bus.req0_wr_data = 16'($urandom);
        end
        if (q1.size() > 0 && q1[0].delay == 0) begin
            bus.req1_valid = 1'b1; bus.req1_wr = q1[0].wr;
            bus.req1_addr = q1[0].addr; bus.req1_wr_data = q1[0].data;
        end else begin
            bus.req1_valid = 1'b0; bus.req1_wr = 1'($urandom);
            bus.req1_addr = 3'($urandom); bus.req1_wr_data = 16'($urandom);
        end
    endtask

    // One clock cycle: drive, compare every output with the model, advance the model at the edge.
    task automatic cycle();
        bit v0, v1, idle, r0, r1;
        drive();
        #1;
        v0   = (q0.size() > 0) && (q0[0].delay == 0);
        v1   = (q1.size() > 0) && (q1[0].delay == 0);
        idle = (now >= free_at);
        r0   = idle && v0 && (ptr == 0 || !v1);
        r1   = idle && v1 && (ptr == 1 || !v0);
        if (now == rsp_cyc) last_rsp = rsp_exp;
        chk("req0_ready",  32'(bus.req0_ready),  32'(r0));
        chk("req1_ready",  32'(bus.req1_ready),  32'(r1));
        chk("busy",        32'(bus.busy),        32'(!idle));
        chk("rf_wr_en",    32'(bus.rf_wr_en),    32'(now == strobe_cyc && strobe_wr));
        chk("rf_rd_en",    32'(bus.rf_rd_en),    32'(now == strobe_cyc && !strobe_wr));
        chk("rf_address",  32'(bus.rf_address),  32'(last_addr));
        chk("rf_wr_data",  32'(bus.rf_wr_data),  32'(last_wdata));
        chk("rsp0_valid",  32'(bus.rsp0_valid),  32'(now == rsp_cyc && rsp_owner == 0));
        chk("rsp1_valid",  32'(bus.rsp1_valid),  32'(now == rsp_cyc && rsp_owner == 1));
        chk("rsp_rd_data", 32'(bus.rsp_rd_data), 32'(last_rsp));
        if (bus.rf_wr_en === 1'b1) begin
            wren_cnt++; wren_addr = bus.rf_address; wren_data = bus.rf_wr_data;
        end
        if (bus.rsp0_valid === 1'b1) begin rsp0_cnt++; rsp0_data.push_back(bus.rsp_rd_data); end
        if (bus.rsp1_valid === 1'b1) begin rsp1_cnt++; rsp1_data.push_back(bus.rsp_rd_data); end
        if (bus.req0_ready === 1'b1) begin gnt_log.push_back(0); rdy0_cyc.push_back(now); end
        if (bus.req1_ready === 1'b1) begin gnt_log.push_back(1); acc1_cyc.push_back(now); end
        @(posedge clk);
        if (r0 || r1) begin
            txn_t t;
            t = r0 ? q0.pop_front() : q1.pop_front();
            last_addr  = t.addr;
            last_wdata = t.data;
            strobe_cyc = now + 1;
            strobe_wr  = t.wr;
            if (t.wr) begin
                ref_mem[t.addr] = t.data;
                free_at = now + 2;
            end else begin
                rsp_exp   = ref_mem[t.addr];
                rsp_owner = r0 ? 0 : 1;
                rsp_cyc   = now + 3;
                free_at   = now + 3;
            end
            ptr = r0 ? 1 : 0;
        end
        if (!v0 && q0.size() > 0 && q0[0].delay > 0) q0[0].delay = q0[0].delay - 1;
        if (!v1 && q1.size() > 0 && q1[0].delay > 0) q1[0].delay = q1[0].delay - 1;
        now++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || now < free_at || now <= rsp_cyc) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk(tag, 32'(q0.size() == 0 && q1.size() == 0 && now >= free_at), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int start;
        model_reset();
        clear_mon();

        // Reset values with random requester inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = 1'($urandom); bus.req0_wr = 1'($urandom);
            bus.req0_addr = 3'($urandom); bus.req0_wr_data = 16'($urandom);
            bus.req1_valid = 1'($urandom); bus.req1_wr = 1'($urandom);
            bus.req1_addr = 3'($urandom); bus.req1_wr_data = 16'($urandom);
            #3;
            chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            chk("rst_rsp",   32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            chk("rst_data",  32'(bus.rsp_rd_data), 32'd0);
            chk("rst_busy",  32'(bus.busy), 32'd0);
            chk("rst_rf",    32'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single write then read by requester 0.
        clear_mon();
        q0.push_back(mk(1'b1, 3'd5, 16'd10, 0));
        q0.push_back(mk(1'b0, 3'd5, 16'hbeef, 0));
        drain("t1_drain", 40);
        chk("t1_wren_cnt",  32'(wren_cnt), 32'd1);
        chk("t1_wren_addr", 32'(wren_addr), 32'd5);
        chk("t1_wren_data", 32'(wren_data), 32'd10);
        chk("t1_rsp0_cnt",  32'(rsp0_cnt), 32'd1);
        chk("t1_rsp0_data", (rsp0_data.size() > 0) ? 32'(rsp0_data[0]) : 32'hffff_ffff, 32'd10);
        chk("t1_rsp1_cnt",  32'(rsp1_cnt), 32'd0);

        // Contention from reset: 0 reads addr 2, 1 writes 3 to addr 2.
        apply_reset();
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b0, 3'd2, 16'h0, 0));
            q1.push_back(mk(1'b1, 3'd2, 16'd3, 0));
        end
        drain("t2_drain", 40);
        chk("t2_gnt_cnt", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_gnt%0d", i), (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'hffff_ffff, 32'(i % 2));
        chk("t2_rsp_old", (rsp0_data.size() > 0) ? 32'(rsp0_data[0]) : 32'hffff_ffff, 32'd0);
        chk("t2_rsp_new", (rsp0_data.size() > 1) ? 32'(rsp0_data[1]) : 32'hffff_ffff, 32'd3);

        // Requester 1 streaming writes alone.
        clear_mon();
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 3'(i), 16'($urandom), 0));
        drain("t3_drain", 40);
        chk("t3_acc_cnt", 32'(acc1_cyc.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t3_gap%0d", i), (acc1_cyc.size() > i) ? 32'(acc1_cyc[i] - acc1_cyc[i-1]) : 32'hffff_ffff, 32'd2);
        chk("t3_rdy0", 32'(rdy0_cyc.size()), 32'd0);

        // Hold rule: requester 0 arrives while a read by 1 is in flight.
        clear_mon();
        start = now;
        q1.push_back(mk(1'b0, 3'd5, 16'h1234, 0));
        q0.push_back(mk(1'b0, 3'd0, 16'h5678, 1));
        drain("t4_drain", 40);
        chk("t4_rdy0_first", (rdy0_cyc.size() > 0) ? 32'(rdy0_cyc[0] - start) : 32'hffff_ffff, 32'd3);
        chk("t4_rsp1_data", (rsp1_data.size() > 0) ? 32'(rsp1_data[0]) : 32'hffff_ffff, 32'd10);

        // Reset during CAPTURE aborts the read with no response.
        clear_mon();
        q0.push_back(mk(1'b0, 3'd5, 16'h0, 0));
        cycle();
        cycle();
        chk("t5_busy_capture", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_no_rsp0", 32'(bus.rsp0_valid), 32'd0);
        chk("t5_rsp_data", 32'(bus.rsp_rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("t5_rsp0_cnt", 32'(rsp0_cnt), 32'd0);
        clear_mon();
        q0.push_back(mk(1'b0, 3'd5, 16'h0, 0));
        drain("t5_drain", 40);
        chk("t5_after_cnt",  32'(rsp0_cnt), 32'd1);
        chk("t5_after_data", (rsp0_data.size() > 0) ? 32'(rsp0_data[0]) : 32'hffff_ffff, 32'd10);

        // Random mixed traffic from both requesters.
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk(1'($urandom), 3'($urandom), 16'($urandom), int'($urandom_range(0, 3))));
            q1.push_back(mk(1'($urandom), 3'($urandom), 16'($urandom), int'($urandom_range(0, 3))));
        end
        drain("t6_drain", 2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
